// File: rtl/pim_tile_aggregator.sv
// pim_tile_aggregator
// Gathers result tiles from up to MAX_PIM_UNITS PIM units into a square
// (GRID_DIM*TILE_SIZE) result buffer, then streams the active matrix out one
// row per beat over a valid/ready handshake.
//
// Optional feature macro: PIM_AGG_ACCUM_EN
//   defined   - each unit strobe is added element-wise into the buffer and
//               a unit is complete after k_passes strobes (0 counts as 1).
//   undefined - each unit is captured once; k_passes is ignored.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   start           : job start pulse, config sampled on the same edge
//   matrix_size     : active matrix edge, 1..GRID_DIM*TILE_SIZE
//   pim_units_used  : participating units, 1..MAX_PIM_UNITS
//   k_passes        : partial-sum passes per unit (accumulation build only)
//   pim_results     : per-unit tile data, [unit][row][col]
//   pim_valid       : per-unit one-cycle result strobe
//   out_valid/out_ready : row handshake
//   out_row         : one matrix row, column 0 in the LSBs
//   out_row_idx     : index of out_row
//   out_last        : out_row is row matrix_size-1
//   busy            : job in progress
//   done            : one-cycle pulse at job completion
//   cfg_err         : one-cycle pulse when start is rejected
module pim_tile_aggregator #(
    parameter int ELEM_WIDTH    = 32,
    parameter int TILE_SIZE     = 8,
    parameter int GRID_DIM      = 2,
    parameter int MAX_PIM_UNITS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [15:0]                            matrix_size,
    input  logic [3:0]                             pim_units_used,
    input  logic [7:0]                             k_passes,
    input  logic [MAX_PIM_UNITS-1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][ELEM_WIDTH-1:0] pim_results,
    input  logic [MAX_PIM_UNITS-1:0]               pim_valid,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [GRID_DIM*TILE_SIZE*ELEM_WIDTH-1:0] out_row,
    output logic [15:0]                            out_row_idx,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   cfg_err
);

    localparam int MAT_DIM = GRID_DIM * TILE_SIZE;
    localparam int ROW_W   = MAT_DIM * ELEM_WIDTH;
    localparam int IDX_W   = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Unit that owns buffer element [r][c].
    function automatic int tile_unit(input int r, input int c);
        return (r / TILE_SIZE) * GRID_DIM + (c / TILE_SIZE);
    endfunction

    state_t                     state_r, state_next_s;
    logic [15:0]                size_r;
    logic [3:0]                 used_r;
    logic [MAX_PIM_UNITS-1:0]   got_r, got_next_s, unit_en_s, capture_s;
    logic [ELEM_WIDTH-1:0]      buf_r      [MAT_DIM][MAT_DIM];
    logic [ELEM_WIDTH-1:0]      buf_next_s [MAT_DIM][MAT_DIM];
    logic                       cfg_ok_s, clear_s, cfg_err_s, all_got_s;
    logic                       out_valid_r, out_last_r, busy_r, done_r, cfg_err_r;
    logic [ROW_W-1:0]           out_row_r, out_row_next_s;
    logic [15:0]                out_row_idx_r, idx_next_s;
    logic                       out_valid_next_s, out_last_next_s, load_row_s, zero_row_s;

`ifdef PIM_AGG_ACCUM_EN
    logic [7:0]                      kp_r, kp_eff_s;
    logic [MAX_PIM_UNITS-1:0][7:0]   pass_r, pass_next_s;
`else
    logic                            k_passes_unused_s;
    assign k_passes_unused_s = ^k_passes;
`endif

    assign cfg_ok_s = (matrix_size != 16'd0) && (matrix_size <= 16'(MAT_DIM)) &&
                      (pim_units_used != 4'd0) &&
                      (32'(pim_units_used) <= 32'(MAX_PIM_UNITS));

    // Units participating in the latched job, and strobes that count this cycle.
    always_comb begin
        unit_en_s = {MAX_PIM_UNITS{1'b0}};
        capture_s = {MAX_PIM_UNITS{1'b0}};
        for (int u = 0; u < MAX_PIM_UNITS; u++) begin
            unit_en_s[u] = (32'(u) < 32'(used_r));
            capture_s[u] = (state_r == ST_COLLECT) && pim_valid[u] && unit_en_s[u] && !got_r[u];
        end
    end

    // Completion mask (and pass counters when accumulating).
    always_comb begin
        got_next_s = got_r;
`ifdef PIM_AGG_ACCUM_EN
        pass_next_s = pass_r;
        kp_eff_s    = (kp_r == 8'd0) ? 8'd1 : kp_r;
`endif
        if (clear_s) begin
            got_next_s = {MAX_PIM_UNITS{1'b0}};
`ifdef PIM_AGG_ACCUM_EN
            pass_next_s = {(MAX_PIM_UNITS*8){1'b0}};
`endif
        end else begin
            for (int u = 0; u < MAX_PIM_UNITS; u++) begin
                if (capture_s[u]) begin
`ifdef PIM_AGG_ACCUM_EN
                    pass_next_s[u] = pass_r[u] + 8'd1;
                    got_next_s[u]  = (pass_next_s[u] >= kp_eff_s);
`else
                    got_next_s[u]  = 1'b1;
`endif
                end else begin
                    got_next_s[u] = got_r[u];
                end
            end
        end
    end

    assign all_got_s = &(got_next_s | ~unit_en_s);

    // Next buffer contents: cleared on job start, tile writes during COLLECT.
    always_comb begin
        for (int r = 0; r < MAT_DIM; r++) begin
            for (int c = 0; c < MAT_DIM; c++) begin
                if (clear_s) begin
                    buf_next_s[r][c] = {ELEM_WIDTH{1'b0}};
                end else if (capture_s[tile_unit(r, c)]) begin
`ifdef PIM_AGG_ACCUM_EN
                    buf_next_s[r][c] = buf_r[r][c] +
                        pim_results[tile_unit(r, c)][r % TILE_SIZE][c % TILE_SIZE];
`else
                    buf_next_s[r][c] = pim_results[tile_unit(r, c)][r % TILE_SIZE][c % TILE_SIZE];
`endif
                end else begin
                    buf_next_s[r][c] = buf_r[r][c];
                end
            end
        end
    end

    // Job FSM next-state.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        cfg_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && cfg_ok_s) begin
                    state_next_s = ST_COLLECT;
                    clear_s      = 1'b1;
                end else if (start) begin
                    cfg_err_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (all_got_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (out_valid_r && out_ready && out_last_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Output row sequencing. The first row is read from the next-buffer view so
    // the tile captured on the completing edge is already visible in row 0.
    always_comb begin
        out_valid_next_s = out_valid_r;
        out_last_next_s  = out_last_r;
        idx_next_s       = out_row_idx_r;
        load_row_s       = 1'b0;
        zero_row_s       = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (all_got_s) begin
                    out_valid_next_s = 1'b1;
                    idx_next_s       = 16'd0;
                    out_last_next_s  = (size_r == 16'd1);
                    load_row_s       = 1'b1;
                end else begin
                    out_valid_next_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (out_valid_r && out_ready && out_last_r) begin
                    out_valid_next_s = 1'b0;
                    out_last_next_s  = 1'b0;
                    idx_next_s       = 16'd0;
                    zero_row_s       = 1'b1;
                end else if (out_valid_r && out_ready) begin
                    idx_next_s       = out_row_idx_r + 16'd1;
                    out_last_next_s  = ((out_row_idx_r + 16'd1) == (size_r - 16'd1));
                    load_row_s       = 1'b1;
                end else begin
                    load_row_s       = 1'b0;
                end
            end
            default: begin
                out_valid_next_s = 1'b0;
            end
        endcase

        out_row_next_s = out_row_r;
        for (int c = 0; c < MAT_DIM; c++) begin
            if (zero_row_s) begin
                out_row_next_s[c*ELEM_WIDTH +: ELEM_WIDTH] = {ELEM_WIDTH{1'b0}};
            end else if (load_row_s) begin
                out_row_next_s[c*ELEM_WIDTH +: ELEM_WIDTH] = (16'(c) < size_r) ?
                    buf_next_s[idx_next_s[IDX_W-1:0]][c] : {ELEM_WIDTH{1'b0}};
            end else begin
                out_row_next_s[c*ELEM_WIDTH +: ELEM_WIDTH] = out_row_r[c*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    // Control state, latched config and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            size_r        <= 16'd0;
            used_r        <= 4'd0;
            got_r         <= {MAX_PIM_UNITS{1'b0}};
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_row_r     <= {ROW_W{1'b0}};
            out_row_idx_r <= 16'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            cfg_err_r     <= 1'b0;
`ifdef PIM_AGG_ACCUM_EN
            kp_r          <= 8'd0;
            pass_r        <= {(MAX_PIM_UNITS*8){1'b0}};
`endif
        end else begin
            state_r       <= state_next_s;
            got_r         <= got_next_s;
            out_valid_r   <= out_valid_next_s;
            out_last_r    <= out_last_next_s;
            out_row_r     <= out_row_next_s;
            out_row_idx_r <= idx_next_s;
            busy_r        <= (state_next_s != ST_IDLE);
            done_r        <= (state_next_s == ST_DONE);
            cfg_err_r     <= cfg_err_s;
            if (clear_s) begin
                size_r <= matrix_size;
                used_r <= pim_units_used;
`ifdef PIM_AGG_ACCUM_EN
                kp_r   <= k_passes;
`endif
            end
`ifdef PIM_AGG_ACCUM_EN
            pass_r <= pass_next_s;
`endif
        end
    end

    // Result buffer; contents are don't-care until a job clears them.
    always_ff @(posedge clk) begin
        buf_r <= buf_next_s;
    end

    assign out_valid   = out_valid_r;
    assign out_row     = out_row_r;
    assign out_row_idx = out_row_idx_r;
    assign out_last    = out_last_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_pim_tile_aggregator.sv
// Self-checking bench for pim_tile_aggregator: a table of job vectors plus
// hand-written sequences for stalls, ignored strobes/starts and mid-job reset.
module tb_pim_tile_aggregator;

    localparam int EW = 32;
    localparam int TS = 8;
    localparam int GD = 2;
    localparam int MU = 4;
    localparam int MD = GD * TS;
    localparam int RW = MD * EW;

    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic [15:0] matrix_size;
    logic [3:0]  pim_units_used;
    logic [7:0]  k_passes;
    logic [MU-1:0][TS-1:0][TS-1:0][EW-1:0] pim_results;
    logic [MU-1:0] pim_valid;
    logic out_valid, out_last, busy, done, cfg_err;
    logic [RW-1:0] out_row;
    logic [15:0] out_row_idx;

    int checks = 0;
    int failures = 0;

    pim_tile_aggregator #(.ELEM_WIDTH(EW), .TILE_SIZE(TS), .GRID_DIM(GD), .MAX_PIM_UNITS(MU)) dut (
        .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
        .pim_units_used(pim_units_used), .k_passes(k_passes), .pim_results(pim_results),
        .pim_valid(pim_valid), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          size;
        int          used;
        bit          err;
        logic [31:0] base;
        bit          stall;
    } vec_t;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected row: unit u's tile holds vals[u]; unused units and columns beyond size read 0.
    function automatic logic [RW-1:0] exp_row(input int r, input int size, input int used,
                                             input logic [MU-1:0][EW-1:0] vals);
        logic [RW-1:0] row;
        int u;
        row = '0;
        for (int c = 0; c < MD; c++) begin
            u = (r / TS) * GD + (c / TS);
            if (c < size && u < used) row[c*EW +: EW] = vals[u];
        end
        return row;
    endfunction

    task automatic start_job(input int size, input int used, input int kp);
        matrix_size    = 16'(size);
        pim_units_used = 4'(used);
        k_passes       = 8'(kp);
        start          = 1'b1;
        step();
        start          = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic strobe(input logic [MU-1:0] mask, input logic [MU-1:0][EW-1:0] vals);
        for (int u = 0; u < MU; u++) pim_results[u] = {(TS*TS){vals[u]}};
        pim_valid = mask;
        step();
        pim_valid = '0;
    endtask

    // Consume the job's rows, optionally with out_ready following 1,0,0,1.
    task automatic drain(input int size, input int used, input logic [MU-1:0][EW-1:0] vals,
                         input bit stall);
        logic [0:3] pat;
        int exp_idx;
        int cyc;
        bit finished;
        pat = 4'b1001;
        exp_idx = 0;
        cyc = 0;
        finished = 1'b0;
        while (!finished && cyc < 200) begin
            out_ready = stall ? pat[cyc % 4] : 1'b1;
            chk("out_valid", out_valid, 1'b1);
            chk("row_idx", out_row_idx, 16'(exp_idx));
            chk("row_data", out_row, exp_row(exp_idx, size, used, vals));
            chk("out_last", out_last, (exp_idx == size - 1));
            chk("no_early_done", done, 1'b0);
            if (out_ready) begin
                if (exp_idx == size - 1) finished = 1'b1;
                exp_idx++;
            end
            step();
            cyc++;
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d rows expected %0d", exp_idx, size);
        end
        out_ready = 1'b1;
        chk("done_pulse", done, 1'b1);
        chk("valid_low_after_last", out_valid, 1'b0);
        step();
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        vec_t vecs[9];
        logic [MU-1:0][EW-1:0] v;
        logic [MU-1:0][EW-1:0] vexp;
        bit saw_done;

        vecs[0] = '{16, 4, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{5,  1, 1'b0, 32'h0000_0064, 1'b0};
        vecs[2] = '{17, 4, 1'b1, 32'h0,         1'b0};
        vecs[3] = '{16, 0, 1'b1, 32'h0,         1'b0};
        vecs[4] = '{0,  2, 1'b1, 32'h0,         1'b0};
        vecs[5] = '{16, 5, 1'b1, 32'h0,         1'b0};
        vecs[6] = '{12, 3, 1'b0, 32'h0000_0040, 1'b1};
        vecs[7] = '{1,  4, 1'b0, 32'h0000_0007, 1'b0};
        vecs[8] = '{9,  2, 1'b0, 32'h0000_0020, 1'b1};

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        matrix_size = '0; pim_units_used = '0; k_passes = '0;
        pim_results = '0; pim_valid = '0;
        step();
        step();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_row", out_row, '0);
        chk("rst_idx", out_row_idx, 16'd0);
        chk("rst_last", out_last, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].err) begin
                matrix_size = 16'(vecs[i].size);
                pim_units_used = 4'(vecs[i].used);
                start = 1'b1;
                step();
                start = 1'b0;
                chk("cfg_err_pulse", cfg_err, 1'b1);
                chk("cfg_err_not_busy", busy, 1'b0);
                step();
                chk("cfg_err_one_cycle", cfg_err, 1'b0);
                chk("cfg_err_stay_idle", busy, 1'b0);
            end else begin
                start_job(vecs[i].size, vecs[i].used, 1);
                for (int u = 0; u < MU; u++)
                    v[u] = (u < vecs[i].used) ? vecs[i].base + 32'(u) : 32'hDEAD_0000 + 32'(u);
                strobe('1, v);
                drain(vecs[i].size, vecs[i].used, v, vecs[i].stall);
            end
        end

        // start while busy is ignored, repeat strobes and unused-unit strobes ignored.
        start_job(16, 2, 1);
        matrix_size = 16'd17; pim_units_used = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_no_cfg_err", cfg_err, 1'b0);
        matrix_size = 16'd5; pim_units_used = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        v = '0; v[0] = 32'd10;
        strobe(4'b0001, v);
        chk("partial_collect_wait", out_valid, 1'b0);
        v[0] = 32'd99; v[2] = 32'd77;
        strobe(4'b0101, v);
        chk("repeat_strobe_wait", out_valid, 1'b0);
        v = '0; v[1] = 32'd11;
        strobe(4'b0010, v);
        vexp = '0; vexp[0] = 32'd10; vexp[1] = 32'd11;
        drain(16, 2, vexp, 1'b0);

        // Reset in the middle of DRAIN, then a fresh job.
        start_job(16, 4, 1);
        for (int u = 0; u < MU; u++) v[u] = 32'h50 + 32'(u);
        strobe('1, v);
        out_ready = 1'b1;
        step(); step(); step();
        chk("pre_reset_row3", out_row_idx, 16'd3);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_row", out_row, '0);
        chk("midrst_idx", out_row_idx, 16'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_last", out_last, 1'b0);
        step();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        chk("no_done_after_reset", saw_done, 1'b0);
        start_job(16, 4, 1);
        for (int u = 0; u < MU; u++) v[u] = 32'h60 + 32'(u);
        strobe('1, v);
        drain(16, 4, v, 1'b0);

`ifdef PIM_AGG_ACCUM_EN
        start_job(16, 4, 3);
        v = {MU{32'd2}};
        strobe('1, v);
        strobe('1, v);
        chk("accum_two_passes_wait", out_valid, 1'b0);
        strobe('1, v);
        drain(16, 4, {MU{32'd6}}, 1'b0);
        start_job(16, 4, 2);
        strobe('1, {MU{32'hFFFF_FFFF}});
        strobe('1, {MU{32'd1}});
        drain(16, 4, {MU{32'd0}}, 1'b0);
        start_job(8, 1, 0);
        strobe('1, {MU{32'd5}});
        drain(8, 1, {MU{32'd5}}, 1'b0);
`else
        start_job(16, 4, 3);
        for (int u = 0; u < MU; u++) v[u] = 32'h70 + 32'(u);
        strobe('1, v);
        drain(16, 4, v, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pim_tile_aggregator.md
# pim_tile_aggregator

Collects per-unit result tiles from up to `MAX_PIM_UNITS` PIM units into one `GRID_DIM*TILE_SIZE` square result buffer. It then streams the assembled matrix to the top level one row per beat over a valid/ready handshake. It replaces the single-shot, fixed-2x2 aggregation path: any grid size, a per-job size and unit count, explicit job framing and backpressure. It sits between the PIM array and the top-level result writeback.

## Interface
- `ELEM_WIDTH`, 32, bits per matrix element
- `TILE_SIZE`, 8, tile edge produced by one PIM unit
- `GRID_DIM`, 2, tiles per matrix edge; `MAX_PIM_UNITS` must equal `GRID_DIM*GRID_DIM`
- `MAX_PIM_UNITS`, 4, number of PIM result ports
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: job start pulse; config sampled on the same edge
- `matrix_size` in 16: active matrix edge, 1..`GRID_DIM*TILE_SIZE`
- `pim_units_used` in 4: units participating, 1..`MAX_PIM_UNITS`
- `k_passes` in 8: partial-sum passes per unit (used only with `PIM_AGG_ACCUM_EN`)
- `pim_results` in `[MAX_PIM_UNITS][TILE_SIZE][TILE_SIZE]` x `ELEM_WIDTH`: tile data
- `pim_valid` in `MAX_PIM_UNITS`: per-unit one-cycle result strobe
- `out_valid` out 1: output row valid
- `out_ready` in 1: consumer accepts row
- `out_row` out `GRID_DIM*TILE_SIZE*ELEM_WIDTH`: one matrix row, column 0 in the LSBs
- `out_row_idx` out 16: index of `out_row`
- `out_last` out 1: current row is row `matrix_size-1`
- `busy` out 1: state is not IDLE
- `done` out 1: one-cycle pulse at job completion
- `cfg_err` out 1: one-cycle pulse when `start` is rejected

## Operation
- Unit u maps to tile (u / `GRID_DIM`, u % `GRID_DIM`). Element [i][j] goes to buffer [row*TILE_SIZE+i][col*TILE_SIZE+j].
- States: IDLE, COLLECT, DRAIN, DONE.
- **IDLE**
  - On `start` with a valid config: latch `matrix_size`, `pim_units_used` and `k_passes`; clear the buffer, the got mask and the pass counters; go to COLLECT.
  - Invalid config: `matrix_size` 0 or > `GRID_DIM*TILE_SIZE`, or `pim_units_used` 0 or > `MAX_PIM_UNITS`. Pulse `cfg_err` and stay in IDLE.
- **COLLECT**
  - Without accumulation: the first `pim_valid[u]` for u < used stores the tile and sets got[u]. Repeat strobes from a unit whose got bit is set are ignored.
  - Strobes from units >= used are ignored.
  - Strobes from different units in the same cycle are all captured.
  - When got[u] is set for every u < used, go to DRAIN.
- **DRAIN**
  - Present rows 0..`matrix_size`-1 in order.
  - Columns >= `matrix_size` are driven to zero.
  - Tiles from units that were not used read as zero.
  - Advance on `out_valid && out_ready`. After the last handshake, go to DONE.
- **DONE**: pulse `done` for one cycle, then go to IDLE.
- `start` while `busy` is ignored and does not raise `cfg_err`. `pim_valid` in IDLE, DRAIN or DONE is ignored.

## Timing
- Reset values: state IDLE; `out_valid`, `out_last`, `busy`, `done`, `cfg_err` all 0; `out_row` 0; `out_row_idx` 0; got mask and pass counters 0; buffer contents don't-care.
- `rst` mid-job aborts immediately; no `done` is issued.
- `start` accepted at edge t: `busy` is 1 from cycle t+1.
- Final tile captured at edge t: `out_valid` rises in cycle t+1 with row 0, so first row latency is 1 cycle.
- Throughput is one row per cycle while `out_ready` is held high.
- `out_row`, `out_row_idx` and `out_last` are registered. They stay stable while `out_valid && !out_ready`.
- `out_valid` does not depend combinationally on `out_ready`.
- Last row handshake at edge t: `out_valid` = 0 and `done` = 1 in cycle t+1; IDLE in cycle t+2.
- `cfg_err` is issued in the cycle after the rejected `start`.

## Configuration
- `PIM_AGG_ACCUM_EN` defined:
  - In COLLECT, each `pim_valid[u]` adds the tile element-wise into the buffer, modulo 2^`ELEM_WIDTH` with no saturation, and increments pass_cnt[u].
  - got[u] is set when pass_cnt[u] reaches the latched `k_passes`. Further strobes from that unit are ignored.
  - `k_passes` = 0 is treated as 1.
- `PIM_AGG_ACCUM_EN` undefined: `k_passes` is ignored and no adders or pass counters are built. Behaviour is the single-capture mode.

## Test plan
- Defaults, size 16, used 4, each tile filled with the unit id, `out_ready` held 1 -> rows 0-7 read cols 0-7 = 0 and 8-15 = 1; rows 8-15 read 2 and 3 respectively; 16 consecutive beats, `out_last` on row 15, `done` pulses one cycle later.
- Size 5, used 1 -> 5 beats; cols 0-4 carry data, cols 5-15 are 0; `out_last` on `out_row_idx` 4.
- `out_ready` toggled 1,0,0,1 during DRAIN -> `out_row` and `out_row_idx` stay stable across the stall cycles; no row lost or duplicated.
- `start` with size 17 or used 0 -> `cfg_err` pulse; `busy` stays 0. `start` during COLLECT -> ignored.
- `rst` asserted mid-DRAIN at row 3 -> all outputs 0 immediately; no `done`; a fresh job then completes normally.
- With `PIM_AGG_ACCUM_EN`, `k_passes` 3, each unit strobes a tile of all 2 three times -> every output element is 6. Elements 0xFFFFFFFF + 1 -> wrap to 0.
